hsid_vec_dist_acc: RTL and testbench

Multi-lane, mode-selectable vector distance accumulator for the HSID pixel/reference comparison datapath. Each beat carries `LANES` band samples from two spectra. The block computes per-lane squared difference (SED) or absolute difference (SAD), reduces the lanes with an adder tree and accumulates across beats. It emits a running distance every beat and flags the final one. It is the wide successor of the single-lane squared-difference accumulator: vector-level restart, lane masking, a SAD mode and saturating overflow are new.

---
 rtl/hsid_pkg.sv | 12 +
 rtl/hsid_lane_dist.sv | 39 +++
 rtl/hsid_vec_dist_acc.sv | 131 +++++++++++++
 tb/tb_hsid_vec_dist_acc.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/hsid_pkg.sv
// hsid_pkg: shared widths, distance mode enum and sum-width helper for the HSID distance datapath
package hsid_pkg;
  localparam int HSID_DATA_WIDTH = 16;
  localparam int HSID_DATA_WIDTH_ACC = 34;
  typedef enum logic {
    HSID_SED = 1'b0,
    HSID_SAD = 1'b1
  } hsid_dist_mode_t;
  function automatic int hsid_sum_width(input int dw, input int lanes);
    return 2 * dw + $clog2(lanes);
  endfunction
endpackage

// File: rtl/hsid_lane_dist.sv
// hsid_lane_dist: one lane, registered difference then registered masked squared or absolute difference
module hsid_lane_dist
  import hsid_pkg::*;
#(
  parameter int DATA_WIDTH = HSID_DATA_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDTH-1:0]     a,
  input  logic [DATA_WIDTH-1:0]     b,
  input  logic                      keep,
  input  logic                      mode,
  output logic [2*DATA_WIDTH-1:0]   val
);
  logic [DATA_WIDTH:0] diff_d, diff_q;
  logic keep_q, mode_q;
  logic [DATA_WIDTH-1:0] mag;
  logic [2*DATA_WIDTH-1:0] sq, val_d, val_q;
  always_comb begin
    diff_d = {1'b0, a} - {1'b0, b};
    mag = diff_q[DATA_WIDTH] ? ~diff_q[DATA_WIDTH-1:0] + DATA_WIDTH'(1) : diff_q[DATA_WIDTH-1:0];
    sq = {{DATA_WIDTH{1'b0}}, mag} * {{DATA_WIDTH{1'b0}}, mag};
    val_d = !keep_q ? '0 : (mode_q == HSID_SAD) ? {{DATA_WIDTH{1'b0}}, mag} : sq;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      diff_q <= '0;
      keep_q <= 1'b0;
      mode_q <= 1'b0;
      val_q <= '0;
    end else begin
      diff_q <= diff_d;
      keep_q <= keep;
      mode_q <= mode;
      val_q <= val_d;
    end
  end
  assign val = val_q;
endmodule

// File: rtl/hsid_vec_dist_acc.sv
// hsid_vec_dist_acc: multi-lane SED/SAD vector distance accumulator with masking, restart and saturation
module hsid_vec_dist_acc
  import hsid_pkg::*;
#(
  parameter int DATA_WIDTH = HSID_DATA_WIDTH,
  parameter int LANES = 4,
  parameter int DATA_WIDTH_ACC = HSID_DATA_WIDTH_ACC
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear,
  input  logic                          mode,
  input  logic                          initial_acc_en,
  input  logic [DATA_WIDTH_ACC-1:0]     initial_acc,
  input  logic                          data_in_valid,
  input  logic [LANES*DATA_WIDTH-1:0]   data_in_a,
  input  logic [LANES*DATA_WIDTH-1:0]   data_in_b,
  input  logic [LANES-1:0]              data_in_keep,
  input  logic                          data_in_last,
  output logic                          acc_valid,
  output logic [DATA_WIDTH_ACC-1:0]     acc_value,
  output logic                          acc_last,
  output logic                          acc_of,
  output logic [15:0]                   acc_count
);
  localparam int SW = hsid_sum_width(DATA_WIDTH, LANES);
  localparam int PW = 2 * DATA_WIDTH;
  localparam int AW = DATA_WIDTH_ACC;
  logic flush;
  logic [LANES*DATA_WIDTH-1:0] a_q, b_q;
  logic [LANES-1:0] keep_q;
  logic mode_q;
  logic [3:0] v_d, v_q, l_d, l_q, e_d, e_q;
  logic [AW-1:0] init_d [4];
  logic [AW-1:0] init_q [4];
  logic [PW-1:0] val [LANES];
  logic [SW-1:0] sum_d, sum_q;
  logic start;
  logic [AW-1:0] prev;
  logic [AW:0] sum_ext, ext;
  logic [AW-1:0] acc_d, acc_q;
  logic of_d, of_q, pend_d, pend_q, valid_d, valid_q, last_d, last_q;
  logic [15:0] cnt_d, cnt_q;
  assign flush = rst | clear;
  always_ff @(posedge clk) begin
    if (flush) begin
      a_q <= '0;
      b_q <= '0;
      keep_q <= '0;
      mode_q <= 1'b0;
    end else begin
      a_q <= data_in_a;
      b_q <= data_in_b;
      keep_q <= data_in_keep;
      mode_q <= mode;
    end
  end
  genvar g;
  generate
    for (g = 0; g < LANES; g++) begin : g_lane
      hsid_lane_dist #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
        .clk  (clk),
        .rst  (flush),
        .a    (a_q[g*DATA_WIDTH +: DATA_WIDTH]),
        .b    (b_q[g*DATA_WIDTH +: DATA_WIDTH]),
        .keep (keep_q[g]),
        .mode (mode_q),
        .val  (val[g])
      );
    end
  endgenerate
  always_comb begin
    v_d = {v_q[2:0], data_in_valid};
    l_d = {l_q[2:0], data_in_valid & data_in_last};
    e_d = {e_q[2:0], data_in_valid & initial_acc_en};
    init_d[0] = initial_acc;
    for (int i = 1; i < 4; i++) init_d[i] = init_q[i-1];
    sum_d = '0;
    for (int i = 0; i < LANES; i++) sum_d = sum_d + SW'(val[i]);
  end
  always_ff @(posedge clk) begin
    if (flush) begin
      v_q <= '0;
      l_q <= '0;
      e_q <= '0;
      for (int i = 0; i < 4; i++) init_q[i] <= '0;
      sum_q <= '0;
    end else begin
      v_q <= v_d;
      l_q <= l_d;
      e_q <= e_d;
      for (int i = 0; i < 4; i++) init_q[i] <= init_d[i];
      sum_q <= sum_d;
    end
  end
  always_comb begin
    start = e_q[3] | pend_q;
    prev = start ? (e_q[3] ? init_q[3] : '0) : acc_q;
    sum_ext = '0;
    sum_ext[SW-1:0] = sum_q;
    ext = {1'b0, prev} + sum_ext;
    acc_d = !v_q[3] ? acc_q : ext[AW] ? '1 : ext[AW-1:0];
    of_d = !v_q[3] ? of_q : (of_q & ~start) | ext[AW];
    cnt_d = !v_q[3] ? cnt_q : start ? 16'd1 : (&cnt_q) ? cnt_q : cnt_q + 16'd1;
    pend_d = v_q[3] ? l_q[3] : pend_q;
    valid_d = v_q[3];
    last_d = v_q[3] & l_q[3];
  end
  always_ff @(posedge clk) begin
    if (flush) begin
      acc_q <= '0;
      of_q <= 1'b0;
      cnt_q <= '0;
      pend_q <= 1'b1;
      valid_q <= 1'b0;
      last_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      of_q <= of_d;
      cnt_q <= cnt_d;
      pend_q <= pend_d;
      valid_q <= valid_d;
      last_q <= last_d;
    end
  end
  assign acc_valid = valid_q;
  assign acc_value = acc_q;
  assign acc_last = last_q;
  assign acc_of = of_q;
  assign acc_count = cnt_q;
endmodule

// File: tb/tb_hsid_vec_dist_acc.sv
// tb_hsid_vec_dist_acc: directed self-checking bench with hand-computed distances
module tb_hsid_vec_dist_acc;
  logic clk = 1'b0;
  logic rst, clear, mode, initial_acc_en, data_in_valid, data_in_last;
  logic [33:0] initial_acc;
  logic [63:0] data_in_a, data_in_b;
  logic [3:0] data_in_keep;
  logic acc_valid, acc_last, acc_of;
  logic [33:0] acc_value;
  logic [15:0] acc_count;
  int checks = 0;
  int fails = 0;
  localparam logic [63:0] A1 = 64'h0003_0002_0001_0000;
  localparam logic [63:0] B1 = 64'h0006_0002_0002_0007;
  localparam logic [63:0] A2 = 64'h0007_0006_0005_0004;
  localparam logic [63:0] B2 = 64'h0009_0003_0007_0001;
  localparam logic [33:0] ONES = 34'h3_FFFF_FFFF;
  localparam logic [33:0] NEAR = 34'h3_FFFF_FFF6;
  always #5 clk = ~clk;
  hsid_vec_dist_acc #(.DATA_WIDTH(16), .LANES(4), .DATA_WIDTH_ACC(34)) dut (
    .clk            (clk),
    .rst            (rst),
    .clear          (clear),
    .mode           (mode),
    .initial_acc_en (initial_acc_en),
    .initial_acc    (initial_acc),
    .data_in_valid  (data_in_valid),
    .data_in_a      (data_in_a),
    .data_in_b      (data_in_b),
    .data_in_keep   (data_in_keep),
    .data_in_last   (data_in_last),
    .acc_valid      (acc_valid),
    .acc_value      (acc_value),
    .acc_last       (acc_last),
    .acc_of         (acc_of),
    .acc_count      (acc_count)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic expect_out(input string tag, input logic v, input logic [33:0] val, input logic l, input logic o, input logic [15:0] c);
    chk({tag, ".valid"}, 64'(acc_valid), 64'(v));
    chk({tag, ".value"}, 64'(acc_value), 64'(val));
    chk({tag, ".last"}, 64'(acc_last), 64'(l));
    chk({tag, ".of"}, 64'(acc_of), 64'(o));
    chk({tag, ".count"}, 64'(acc_count), 64'(c));
  endtask
  task automatic drive(input logic v, input logic m, input logic e, input logic [33:0] ini, input logic [63:0] av, input logic [63:0] bv, input logic [3:0] k, input logic l);
    data_in_valid = v;
    mode = m;
    initial_acc_en = e;
    initial_acc = ini;
    data_in_a = av;
    data_in_b = bv;
    data_in_keep = k;
    data_in_last = l;
  endtask
  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0, '0, 1'b0);
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic single(input string tag, input logic m, input logic [3:0] k, input logic [33:0] ini, input logic [33:0] ev, input logic eo);
    drive(1'b1, m, 1'b1, ini, A1, B1, k, 1'b1);
    tick(1);
    idle();
    tick(3);
    chk({tag, ".latency"}, 64'(acc_valid), 64'(0));
    tick(1);
    expect_out(tag, 1'b1, ev, 1'b1, eo, 16'd1);
    tick(1);
    expect_out({tag, ".after"}, 1'b0, ev, 1'b0, eo, 16'd1);
  endtask
  initial begin
    rst = 1'b1;
    clear = 1'b0;
    idle();
    tick(3);
    expect_out("reset", 1'b0, '0, 1'b0, 1'b0, 16'd0);
    rst = 1'b0;
    tick(1);
    single("sed", 1'b0, 4'b1111, '0, 34'd59, 1'b0);
    single("sad", 1'b1, 4'b1111, '0, 34'd11, 1'b0);
    single("keep0011", 1'b0, 4'b0011, '0, 34'd50, 1'b0);
    single("keep0000", 1'b0, 4'b0000, '0, 34'd0, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 34'd10, A1, B1, 4'hF, 1'b0);
    tick(1);
    drive(1'b1, 1'b0, 1'b0, '0, A2, B2, 4'hF, 1'b1);
    tick(1);
    drive(1'b1, 1'b1, 1'b0, '0, A1, B1, 4'hF, 1'b1);
    tick(1);
    idle();
    tick(2);
    expect_out("two.b1", 1'b1, 34'd69, 1'b0, 1'b0, 16'd1);
    tick(1);
    expect_out("two.b2", 1'b1, 34'd95, 1'b1, 1'b0, 16'd2);
    tick(1);
    expect_out("two.next_sad", 1'b1, 34'd11, 1'b1, 1'b0, 16'd1);
    tick(3);
    drive(1'b1, 1'b0, 1'b1, NEAR, A1, B1, 4'hF, 1'b0);
    tick(1);
    drive(1'b1, 1'b0, 1'b0, '0, A2, B2, 4'hF, 1'b1);
    tick(1);
    drive(1'b1, 1'b0, 1'b1, '0, A1, B1, 4'hF, 1'b1);
    tick(1);
    idle();
    tick(2);
    expect_out("of.b1", 1'b1, ONES, 1'b0, 1'b1, 16'd1);
    tick(1);
    expect_out("of.b2", 1'b1, ONES, 1'b1, 1'b1, 16'd2);
    tick(1);
    expect_out("of.next", 1'b1, 34'd59, 1'b1, 1'b0, 16'd1);
    tick(3);
    drive(1'b1, 1'b0, 1'b1, '0, A1, B1, 4'hF, 1'b0);
    tick(1);
    idle();
    tick(1);
    drive(1'b1, 1'b0, 1'b0, '0, A2, B2, 4'hF, 1'b0);
    tick(1);
    idle();
    tick(1);
    drive(1'b1, 1'b0, 1'b0, '0, A1, B1, 4'hF, 1'b1);
    tick(1);
    idle();
    expect_out("bub.c0", 1'b1, 34'd59, 1'b0, 1'b0, 16'd1);
    tick(1);
    expect_out("bub.c1", 1'b0, 34'd59, 1'b0, 1'b0, 16'd1);
    tick(1);
    expect_out("bub.c2", 1'b1, 34'd85, 1'b0, 1'b0, 16'd2);
    tick(1);
    expect_out("bub.c3", 1'b0, 34'd85, 1'b0, 1'b0, 16'd2);
    tick(1);
    expect_out("bub.c4", 1'b1, 34'd144, 1'b1, 1'b0, 16'd3);
    tick(2);
    drive(1'b1, 1'b0, 1'b1, 34'd100, A1, B1, 4'hF, 1'b1);
    tick(1);
    idle();
    tick(1);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    expect_out("clr.flush", 1'b0, '0, 1'b0, 1'b0, 16'd0);
    tick(2);
    expect_out("clr.dropped", 1'b0, '0, 1'b0, 1'b0, 16'd0);
    drive(1'b1, 1'b0, 1'b0, '0, A2, B2, 4'hF, 1'b1);
    tick(1);
    idle();
    tick(4);
    expect_out("clr.fresh", 1'b1, 34'd26, 1'b1, 1'b0, 16'd1);
    tick(2);
    drive(1'b1, 1'b0, 1'b1, '0, A1, B1, 4'hF, 1'b1);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    idle();
    tick(4);
    expect_out("clr.same_cycle", 1'b0, '0, 1'b0, 1'b0, 16'd0);
    drive(1'b1, 1'b0, 1'b1, '0, A1, B1, 4'hF, 1'b0);
    tick(1);
    idle();
    tick(4);
    expect_out("mid.b1", 1'b1, 34'd59, 1'b0, 1'b0, 16'd1);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    expect_out("mid.flush", 1'b0, '0, 1'b0, 1'b0, 16'd0);
    drive(1'b1, 1'b0, 1'b0, '0, A2, B2, 4'hF, 1'b1);
    tick(1);
    idle();
    tick(4);
    expect_out("mid.fresh", 1'b1, 34'd26, 1'b1, 1'b0, 16'd1);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
